// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcode constants, field widths and small
// decode helpers used by the pipeline stages.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

    // How the B operand is sourced for a given opcode.
    typedef enum logic [1:0] {
        BSRC_REG  = 2'd0,
        BSRC_SEXT = 2'd1,
        BSRC_ZEXT = 2'd2
    } bsrc_e;

    function automatic bsrc_e b_source(input logic [OP_W-1:0] op);
        bsrc_e src;
        case (op)
            OP_LW, OP_SW, OP_ADDI: src = BSRC_SEXT;
            OP_ANDI, OP_ORI:       src = BSRC_ZEXT;
            default:               src = BSRC_REG;
        endcase
        return src;
    endfunction

    // Destination register written back by an instruction; 0 means none.
    function automatic logic [REG_W-1:0] dest_reg(input logic [OP_W-1:0]  op,
                                                  input logic [REG_W-1:0] rt,
                                                  input logic [REG_W-1:0] rd);
        logic [REG_W-1:0] dst;
        case (op)
            OP_RTYPE:                    dst = rd;
            OP_LW, OP_ADDI, OP_ANDI,
            OP_ORI:                      dst = rt;
            default:                     dst = '0;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register. The younger EX/MEM
// result has priority over MEM/WB; register 0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [REG_W-1:0]  spec,
    input  logic [DATA_W-1:0] latched,
    input  logic              exmem_regwrite,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data
);

    // Priority select: EX/MEM match, then MEM/WB match, else latched value.
    always_comb begin
        data = latched;
        if (spec != '0) begin
            if (exmem_regwrite && (exmem_rd == spec)) begin
                data = exmem_result;
            end else if (memwb_regwrite && (memwb_rd == spec)) begin
                data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and B-operand selection.
// All id_* inputs pass through a register; only the forwarding candidates
// reach the outputs combinationally.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [OP_W-1:0]   id_funct,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic              exmem_regwrite,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [OP_W-1:0]   ex_funct,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_wreg
);

    logic              valid_reg;
    logic [OP_W-1:0]   opcode_reg;
    logic [OP_W-1:0]   funct_reg;
    logic [REG_W-1:0]  rs_reg;
    logic [REG_W-1:0]  rt_reg;
    logic [REG_W-1:0]  wreg_reg;
    logic [IMM_W-1:0]  imm_reg;
    logic [DATA_W-1:0] rs_data_reg;
    logic [DATA_W-1:0] rt_data_reg;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    fwd_mux u_fwd_rs (
        .spec           (rs_reg),
        .latched        (rs_data_reg),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .data           (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .spec           (rt_reg),
        .latched        (rt_data_reg),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .data           (fwd_rt)
    );

    // Pipeline register: flush kills, stall holds (but refreshes operand data
    // with forwarded values so late writebacks are not lost), else latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            opcode_reg  <= '0;
            funct_reg   <= '0;
            rs_reg      <= '0;
            rt_reg      <= '0;
            wreg_reg    <= '0;
            imm_reg     <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
        end else if (flush) begin
            valid_reg   <= 1'b0;
            opcode_reg  <= '0;
            funct_reg   <= '0;
            wreg_reg    <= '0;
            rs_reg      <= id_rs;
            rt_reg      <= id_rt;
            imm_reg     <= id_imm;
            rs_data_reg <= id_rs_data;
            rt_data_reg <= id_rt_data;
        end else if (stall) begin
            rs_data_reg <= fwd_rs;
            rt_data_reg <= fwd_rt;
        end else begin
            valid_reg   <= id_valid;
            opcode_reg  <= id_valid ? id_opcode : '0;
            funct_reg   <= id_valid ? id_funct : '0;
            wreg_reg    <= id_valid ? dest_reg(id_opcode, id_rt, id_rd) : '0;
            rs_reg      <= id_rs;
            rt_reg      <= id_rt;
            imm_reg     <= id_imm;
            rs_data_reg <= id_rs_data;
            rt_data_reg <= id_rt_data;
        end
    end

    // B operand: extended immediate for I-type ALU/memory ops, else rt.
    always_comb begin
        ex_b = fwd_rt;
        case (b_source(opcode_reg))
            BSRC_SEXT: ex_b = {{(DATA_W-IMM_W){imm_reg[IMM_W-1]}}, imm_reg};
            BSRC_ZEXT: ex_b = {{(DATA_W-IMM_W){1'b0}}, imm_reg};
            default:   ex_b = fwd_rt;
        endcase
    end

    assign ex_valid      = valid_reg;
    assign ex_opcode     = opcode_reg;
    assign ex_funct      = funct_reg;
    assign ex_a          = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_wreg       = wreg_reg;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  hold current EX contents (hazard unit).
REQ-005 flush  in  1  kill the instruction being latched (branch/jump redirect).
REQ-006 id_valid  in  1  decode stage holds a real instruction.
REQ-007 id_opcode, id_funct  in  6 each  decoded instruction fields.
REQ-008 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-009 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-010 id_imm  in  16  immediate field.
REQ-011 exmem_regwrite, exmem_rd, exmem_result  in  1/5/32  EX/MEM writeback candidate.
REQ-012 memwb_regwrite, memwb_rd, memwb_result  in  1/5/32  MEM/WB writeback candidate.
REQ-013 ex_valid  out  1  EX stage holds a live instruction.
REQ-014 ex_opcode, ex_funct  out  6 each  fields presented to the ALU.
REQ-015 ex_a, ex_b  out  32 each  forwarded ALU operands.
REQ-016 ex_store_data  out  32  forwarded rt value for stores.
REQ-017 ex_wreg  out  5  destination register, 0 when none.

Function
REQ-018 On each rising edge with flush=0 and stall=0 the block SHALL latch all id_* inputs; latency ID->EX is exactly one cycle.
REQ-019 flush=1 SHALL clear ex_valid, ex_opcode, ex_funct and latched wreg to 0 on the next edge regardless of stall (flush wins).
REQ-020 id_valid=0 SHALL latch as a bubble: ex_valid=0, ex_wreg=0, opcode/funct 0.
REQ-021 stall=1 with flush=0 SHALL hold valid, opcode, funct, specifiers and immediate, but SHALL overwrite the latched rs/rt data with the current forwarded values so a MEM/WB value seen during a stall is not lost.
REQ-022 Forwarding SHALL be combinational from latched rs/rt: EX/MEM match (regwrite=1, rd==spec, spec!=0) first, else MEM/WB match, else latched data.
REQ-023 Register 0 SHALL never be forwarded; its operand is always the latched data.
REQ-024 ex_a SHALL equal the forwarded rs value.
REQ-025 ex_b SHALL equal sign-extended imm for opcodes LW 0x23, SW 0x2B, ADDI 0x08; zero-extended imm for ANDI 0x0C, ORI 0x0D; otherwise forwarded rt.
REQ-026 ex_store_data SHALL always equal forwarded rt.
REQ-027 ex_wreg SHALL be rd for opcode 0x00, rt for 0x23/0x08/0x0C/0x0D, 0 otherwise, and 0 whenever ex_valid=0.
REQ-028 Sign extension SHALL replicate imm[15] into bits 31:16; zero extension fills with 0.
REQ-029 Outputs SHALL have no combinational path from id_* inputs; only forwarding inputs reach outputs combinationally.

Reset
REQ-030 rst_n=0 SHALL immediately clear all latched state; ex_valid, ex_opcode, ex_funct, ex_wreg = 0; ex_a, ex_b, ex_store_data = 0 absent forwarding matches (specifiers reset to 0).
REQ-031 Reset asserted mid-stall SHALL discard the held instruction; first edge after release behaves per REQ-018.

Structure
REQ-032 Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ) SHALL live in the shared mips_pkg package.
REQ-033 Forwarding selection SHALL be one sub-module fwd_mux, instantiated twice (rs, rt).
REQ-034 Implementation SHALL target 120-400 lines of RTL.

Verification
REQ-035 Latch: id ADD rs=1(5) rt=2(7) rd=3 -> next cycle ex_a=5, ex_b=7, ex_wreg=3, ex_valid=1.
REQ-036 Forward priority: latched rs=4, exmem(1,4,0xAA), memwb(1,4,0xBB) -> ex_a=0xAA; exmem_regwrite=0 -> ex_a=0xBB; rs=0 with both rd=0 -> ex_a=latched data.
REQ-037 Stall capture: stall=1 two cycles, memwb(1,rt,0x55) only in first -> ex_b=0x55 in second stall cycle and after release.
REQ-038 Immediates: ADDI imm=0xFFFE -> ex_b=0xFFFFFFFE; ORI imm=0x8001 -> ex_b=0x00008001; SW -> ex_wreg=0, ex_store_data=forwarded rt.
REQ-039 Flush vs stall: flush=1 and stall=1 same edge -> ex_valid=0, ex_wreg=0 next cycle.
REQ-040 Async reset: rst_n low between edges -> ex_valid=0, ex_wreg=0 immediately, no clock required.
